// File: rtl/bus_sram_responder.sv
// rtl/bus_sram_responder.sv - word-bus SRAM target with wait states and byte-masked writes
//
// Purpose: services one request/ready transaction at a time against an
// internal DEPTH x 32-bit SRAM, inserting WAIT_STATES cycles before each
// access and answering with a single-cycle o_ready pulse.
//
// Ports:
//   i_clock     sole clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_request   transaction request, held until o_ready is seen
//   i_rw        1 = write, 0 = read
//   i_address   byte address, bits [1:0] ignored, wraps modulo DEPTH words
//   i_wdata     write data
//   i_wmask     byte enables, bit n enables i_wdata[8n+7:8n]
//   o_rdata     last read result, valid while o_ready is high
//   o_ready     one-cycle completion pulse
module bus_sram_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   input  logic        i_rw,
   input  logic [31:0] i_address,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wmask,
   output logic [31:0] o_rdata,
   output logic        o_ready
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_ACK,
      S_RELEASE
   } state_t;

   state_t            r_state;
   logic [3:0]        r_count;
   logic [AW-1:0]     r_addr;
   logic              r_rw;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wmask;
   logic [31:0]       r_mem [DEPTH];

   // Write commits on the edge leaving ACCESS; an async reset pulls the
   // state out of ACCESS immediately, so an aborted write never lands.
   logic              w_write_en;
   assign w_write_en = (r_state == S_ACCESS) && r_rw;

   always_ff @(posedge i_clock) begin
      if (w_write_en) begin
         for (int b = 0; b < 4; b++) begin
            if (r_wmask[b]) begin
               r_mem[r_addr][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_count <= 4'd0;
         r_addr  <= '0;
         r_rw    <= 1'b0;
         r_wdata <= 32'd0;
         r_wmask <= 4'd0;
         o_rdata <= 32'd0;
         o_ready <= 1'b0;
      end else begin
         o_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_request) begin
                  r_addr  <= i_address[AW+1:2];
                  r_rw    <= i_rw;
                  r_wdata <= i_wdata;
                  r_wmask <= i_wmask;
                  r_count <= 4'(WAIT_STATES);
                  r_state <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
               end
            end
            S_WAIT: begin
               // Leaving on count==1 makes WAIT last exactly WAIT_STATES cycles.
               r_count <= r_count - 4'd1;
               if (r_count == 4'd1) begin
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!r_rw) begin
                  o_rdata <= r_mem[r_addr];
               end
               o_ready <= 1'b1;
               r_state <= S_ACK;
            end
            S_ACK: begin
               r_state <= S_RELEASE;
            end
            S_RELEASE: begin
               // Wait for the initiator to drop its request so a held
               // request is never serviced twice.
               if (!i_request) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_sram_responder.sv
// tb/tb_bus_sram_responder.sv - directed self-checking bench for bus_sram_responder
module tb_bus_sram_responder;

   logic        clk;
   logic        rst;

   logic        rq;
   logic        rw;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic [31:0] rdata;
   logic        ready;

   logic        rq0;
   logic        rw0;
   logic [31:0] addr0;
   logic [31:0] wdata0;
   logic [3:0]  wmask0;
   logic [31:0] rdata0;
   logic        ready0;

   int errors = 0;
   int checks = 0;

   bus_sram_responder #(.DEPTH(1024), .WAIT_STATES(2)) dut (
      .i_clock   (clk),
      .i_reset   (rst),
      .i_request (rq),
      .i_rw      (rw),
      .i_address (addr),
      .i_wdata   (wdata),
      .i_wmask   (wmask),
      .o_rdata   (rdata),
      .o_ready   (ready)
   );

   bus_sram_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
      .i_clock   (clk),
      .i_reset   (rst),
      .i_request (rq0),
      .i_rw      (rw0),
      .i_address (addr0),
      .i_wdata   (wdata0),
      .i_wmask   (wmask0),
      .o_rdata   (rdata0),
      .o_ready   (ready0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One transaction on the WAIT_STATES=2 instance, started at a negedge.
   // lat = negedges after the sampling edge at which ready was seen (-1 on timeout).
   task automatic txn(input logic t_rw, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                      input logic [3:0] t_mask, output logic [31:0] t_rd, output int lat,
                      output logic ready_after);
      rq = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata; wmask = t_mask;
      lat = -1;
      t_rd = 32'hx;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ready) begin
            lat = k;
            t_rd = rdata;
            break;
         end
      end
      @(negedge clk);
      ready_after = ready;
      rq = 1'b0;
      @(negedge clk);
   endtask

   // Same for the WAIT_STATES=0 instance; address is changed after latching.
   task automatic txn0(input logic t_rw, input logic [31:0] t_addr, input logic [31:0] t_alt,
                       input logic [31:0] t_wdata, output logic [31:0] t_rd, output int lat,
                       output time t_ready);
      rq0 = 1'b1; rw0 = t_rw; addr0 = t_addr; wdata0 = t_wdata; wmask0 = 4'hF;
      lat = -1;
      t_rd = 32'hx;
      t_ready = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         addr0 = t_alt;
         wdata0 = ~t_wdata;
         if (ready0) begin
            lat = k;
            t_rd = rdata0;
            t_ready = $time;
            break;
         end
      end
      @(negedge clk);
      rq0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rq = 1'b0; rw = 1'b0; addr = 32'd0; wdata = 32'd0; wmask = 4'd0;
      rq0 = 1'b0; rw0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0; wmask0 = 4'd0;
      repeat (2) @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
      checks++;
      if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] rd; int lat; logic ra;
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, ra);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL basic_wr_latency got=%0d exp=4", lat); end
      checks++;
      if (ra !== 1'b0) begin errors++; $display("FAIL basic_wr_pulse_width got=%b exp=0", ra); end
      checks++;
      if (rdata !== 32'd0) begin errors++; $display("FAIL basic_wr_keeps_rdata got=%h exp=00000000", rdata); end
      txn(1'b0, 32'h10, 32'h0, 4'h0, rd, lat, ra);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL basic_rd_latency got=%0d exp=4", lat); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); end
      checks++;
      if (ra !== 1'b0) begin errors++; $display("FAIL basic_rd_pulse_width got=%b exp=0", ra); end
   endtask

   task automatic test_byte_mask();
      logic [31:0] rd; int lat; logic ra;
      txn(1'b1, 32'h20, 32'h11223344, 4'b1111, rd, lat, ra);
      txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, lat, ra);
      txn(1'b0, 32'h20, 32'h0, 4'h0, rd, lat, ra);
      checks++;
      if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL mask_rd_data got=%h exp=11bb33dd", rd); end
      txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, lat, ra);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL mask_zero_latency got=%0d exp=4", lat); end
      txn(1'b0, 32'h20, 32'h0, 4'h0, rd, lat, ra);
      checks++;
      if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL mask_zero_noop got=%h exp=11bb33dd", rd); end
   endtask

   task automatic test_wrap();
      logic [31:0] rd; int lat; logic ra;
      txn(1'b1, 32'h1004, 32'h12345678, 4'hF, rd, lat, ra);
      txn(1'b0, 32'h0004, 32'h0, 4'h0, rd, lat, ra);
      checks++;
      if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap_rd_0004 got=%h exp=12345678", rd); end
      txn(1'b0, 32'h0006, 32'h0, 4'h0, rd, lat, ra);
      checks++;
      if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap_rd_0006 got=%h exp=12345678", rd); end
   endtask

   task automatic test_held_request();
      logic [31:0] rd; int lat; logic ra; int pulses;
      rq = 1'b1; rw = 1'b0; addr = 32'h10;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ready) begin lat = k; break; end
      end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL held_first_latency got=%0d exp=4", lat); end
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ready) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL held_no_second_ready got=%0d exp=0", pulses); end
      rq = 1'b0;
      @(negedge clk);
      txn(1'b0, 32'h10, 32'h0, 4'h0, rd, lat, ra);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL held_reissue_latency got=%0d exp=4", lat); end
      checks++;
      if (ra !== 1'b0) begin errors++; $display("FAIL held_reissue_pulse got=%b exp=0", ra); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL held_reissue_data got=%h exp=deadbeef", rd); end
   endtask

   task automatic test_back_to_back_ws0();
      logic [31:0] rd; int lat; time t1, t2, t3, tdummy;
      txn0(1'b1, 32'h8, 32'h8, 32'hA5A50001, rd, lat, tdummy);
      txn0(1'b1, 32'hC, 32'hC, 32'h00000077, rd, lat, tdummy);
      // Address switches to 0xC after latching; data must come from 0x8.
      txn0(1'b0, 32'h8, 32'hC, 32'h0, rd, lat, t1);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL ws0_rd1_latency got=%0d exp=2", lat); end
      checks++;
      if (rd !== 32'hA5A50001) begin errors++; $display("FAIL ws0_latched_addr got=%h exp=a5a50001", rd); end
      txn0(1'b1, 32'h8, 32'hC, 32'h0BADF00D, rd, lat, t2);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL ws0_wr_latency got=%0d exp=2", lat); end
      checks++;
      if ((t2 - t1) !== 40) begin errors++; $display("FAIL ws0_interval_1 got=%0t exp=40", t2 - t1); end
      txn0(1'b0, 32'h8, 32'hC, 32'h0, rd, lat, t3);
      checks++;
      if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL ws0_rd_after_wr got=%h exp=0badf00d", rd); end
      checks++;
      if ((t3 - t2) !== 40) begin errors++; $display("FAIL ws0_interval_2 got=%0t exp=40", t3 - t2); end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd; int lat; logic ra; int pulses;
      txn(1'b1, 32'h40, 32'h00000000, 4'hF, rd, lat, ra);
      rq = 1'b1; rw = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D; wmask = 4'hF;
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (ready) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_ready got=%0d exp=0", pulses); end
      checks++;
      if (rdata !== 32'd0) begin errors++; $display("FAIL rst_mid_rdata got=%h exp=00000000", rdata); end
      rq = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_after_ready got=%b exp=0", ready); end
      txn(1'b0, 32'h40, 32'h0, 4'h0, rd, lat, ra);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL rst_mid_rd_latency got=%0d exp=4", lat); end
      checks++;
      if (rd !== 32'h00000000) begin errors++; $display("FAIL rst_mid_write_aborted got=%h exp=00000000", rd); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_mask();
      test_wrap();
      test_held_request();
      test_back_to_back_ws0();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_sram_responder.md
# bus_sram_responder

Bus target that services the request/ready word bus driven by DMA channels and the DualPort arbiter output, backed by an internal word-addressed SRAM. Its address, read-data and write-data buses are 32-bit; writes are byte-masked. It accepts one transaction at a time, inserts a configurable number of wait states, and answers each transaction with a single-cycle ready pulse. The block serves as the on-chip scratch memory for DMA transfers and as the reference target in DMA benches.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, at least 4.
- WAIT_STATES, 2: extra cycles inserted before each access; range 0..15.

Ports:
- i_clock  in  1  sole clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_request  in  1  transaction request; held high by the initiator until o_ready is seen.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  32  byte address; bits [1:0] are ignored.
- i_wdata  in  32  write data.
- i_wmask  in  4  byte enables; bit n enables i_wdata[8n+7:8n].
- o_rdata  out  32  read data; valid while o_ready is high.
- o_ready  out  1  one-cycle completion pulse.

## Operation
- Word index is i_address[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states: IDLE, WAIT, ACCESS, ACK, RELEASE.
- IDLE: when i_request=1, latch address, i_rw, i_wdata and i_wmask. Load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, otherwise go to ACCESS.
- WAIT: decrement the counter each cycle. When the counter reaches 1 at an edge, go to ACCESS. WAIT lasts exactly WAIT_STATES cycles.
- ACCESS: one cycle, with the access committed at the exiting edge. A write updates only the enabled byte lanes; disabled lanes keep their old contents; wmask=0 is a legal no-op write. A read loads o_rdata from memory. Then go to ACK.
- ACK: o_ready=1 for exactly one cycle, then go to RELEASE.
- RELEASE: stay until i_request=0, then go to IDLE. A request held high after ready is never serviced twice.
- Inputs are latched only in IDLE. Changes to i_address, i_wdata, i_rw or i_wmask after latching have no effect on the transaction.
- If i_request drops during WAIT or ACCESS (a protocol violation), the transaction still completes and o_ready still pulses.
- o_rdata holds the last read result. Writes do not modify o_rdata.

## Timing
- Reset values: o_ready=0, o_rdata=0, state IDLE, counter 0.
- SRAM contents are not reset; they are undefined until written.
- Latency: i_request is first sampled high in IDLE at edge E0. o_ready is high in the cycle following edge E0+WAIT_STATES+1, i.e. WAIT_STATES+2 cycles after E0.
- Minimum issue interval is WAIT_STATES+4 cycles. This requires the initiator to drop i_request in the cycle after seeing o_ready.
- A read issued immediately after a write to the same word returns the written data; the write committed in an earlier ACCESS.
- Reset asserted mid-transaction aborts it immediately:
  - o_ready is forced to 0.
  - A write not yet at its ACCESS edge is never performed.
  - After reset deasserts, the FSM is in IDLE; if i_request is still high, that is a new transaction.
- o_ready and o_rdata are registered outputs with no combinational path from any input.

## Test plan
- Reset, WAIT_STATES=2: write 0xDEADBEEF, mask 4'b1111, to address 0x10, then read 0x10 -> o_rdata=0xDEADBEEF. Each o_ready arrives exactly 4 cycles after the request is sampled and lasts one cycle.
- Byte mask: write 0x11223344 with mask 1111 to 0x20, then write 0xAABBCCDD with mask 0101 to 0x20, then read 0x20 -> 0x11BB33DD.
- Wrap-around, DEPTH=1024: write 0x12345678 to 0x1004, then read 0x0004 -> 0x12345678. A read of 0x0006 also returns 0x12345678.
- Held request: keep i_request high for 10 cycles after o_ready -> no second o_ready. Drop i_request, then reissue -> normal latency, single pulse.
- WAIT_STATES=0 with back-to-back read/write/read: ready latency is 2 cycles and the issue interval is 4 cycles. Change i_address after latching -> the result reflects the latched address.
- Reset mid-op: issue a write of 0xCAFEF00D to 0x40 and assert i_reset in the WAIT state. o_ready stays 0 and o_rdata=0. After release, read 0x40 -> the previously written value (pre-seeded 0x0), not 0xCAFEF00D.
